// File: rtl/mont_ladder_ctrl_if.sv
// Unit-side bus of mont_ladder_ctrl: doubler/adder handshakes, operands, results and the
// curve/modulus configuration forwarded to both units.
interface mont_ladder_ctrl_if #(
  parameter int NUM_WIDTH  = 256,
  parameter int WORD_WIDTH = 32
);
  logic                  dbl_start;
  logic [NUM_WIDTH-1:0]  dbl_X, dbl_Z;
  logic                  dbl_ready;
  logic [NUM_WIDTH-1:0]  dbl_X_r, dbl_Z_r;

  logic                  add_start;
  logic [NUM_WIDTH-1:0]  add_X0, add_Z0, add_X1, add_Z1, add_XD, add_ZD;
  logic                  add_ready;
  logic [NUM_WIDTH-1:0]  add_X_r, add_Z_r;

  logic [NUM_WIDTH-1:0]  cfg_A24, cfg_N;
  logic [WORD_WIDTH-1:0] cfg_n;

  modport master (
    output dbl_start, dbl_X, dbl_Z,
    input  dbl_ready, dbl_X_r, dbl_Z_r,
    output add_start, add_X0, add_Z0, add_X1, add_Z1, add_XD, add_ZD,
    input  add_ready, add_X_r, add_Z_r,
    output cfg_A24, cfg_N, cfg_n
  );

  modport slave (
    input  dbl_start, dbl_X, dbl_Z,
    output dbl_ready, dbl_X_r, dbl_Z_r,
    input  add_start, add_X0, add_Z0, add_X1, add_Z1, add_XD, add_ZD,
    output add_ready, add_X_r, add_Z_r,
    input  cfg_A24, cfg_N, cfg_n
  );
endinterface

// File: rtl/mont_ladder_ctrl.sv
// Montgomery-ladder sequencer computing [k]P in (X:Z) form via external doubler/adder units.
// Optional LADDER_CYCLE_CNT_EN adds a saturating 32-bit busy-cycle counter output.
//
// state     | meaning
// IDLE      | waiting for start, inputs latched on start
// LOAD      | k==0 check, R0<=P, bit index to MSB
// SCAN      | skip leading zero bits of k
// INIT      | first doubling: R1 <= 2P
// INIT_WAIT | waiting for the initial doubling
// ISSUE     | launch add(R0,R1) and dbl(R0 or R1) together
// WAIT      | collect both results in any order, then update R0/R1
// DONE      | publish R0 and pulse ready
module mont_ladder_ctrl #(
  parameter int NUM_WIDTH  = 256,
  parameter int WORD_WIDTH = 32,
  parameter int K_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  output logic                  err_zero,
  input  logic [K_WIDTH-1:0]    k,
  input  logic [NUM_WIDTH-1:0]  X_P,
  input  logic [NUM_WIDTH-1:0]  Z_P,
  input  logic [NUM_WIDTH-1:0]  A24,
  input  logic [NUM_WIDTH-1:0]  N,
  input  logic [WORD_WIDTH-1:0] n,
  output logic [NUM_WIDTH-1:0]  X_out,
  output logic [NUM_WIDTH-1:0]  Z_out,
  mont_ladder_ctrl_if.master    unit
`ifdef LADDER_CYCLE_CNT_EN
  , output logic [31:0]         cycle_cnt
`endif
);

  localparam int IW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SCAN, INIT, INIT_WAIT, ISSUE, WAIT, DONE
  } state_t;

  state_t               state;
  logic [K_WIDTH-1:0]   k_reg;
  logic [IW-1:0]        idx;
  logic [NUM_WIDTH-1:0] p_x, p_z, r0_x, r0_z, r1_x, r1_z;
  logic [NUM_WIDTH-1:0] dbl_cx, dbl_cz, add_cx, add_cz;
  logic                 bit_cur, dbl_done, add_done, zero_flag;

  logic [NUM_WIDTH-1:0] dres_x, dres_z, ares_x, ares_z;
  logic                 step_done;

  // A result arriving in the completing cycle is used directly; earlier ones come from the capture regs.
  always_comb begin
    dres_x    = dbl_done ? dbl_cx : unit.dbl_X_r;
    dres_z    = dbl_done ? dbl_cz : unit.dbl_Z_r;
    ares_x    = add_done ? add_cx : unit.add_X_r;
    ares_z    = add_done ? add_cz : unit.add_Z_r;
    step_done = (dbl_done | unit.dbl_ready) & (add_done | unit.add_ready);
  end

  assign unit.add_XD = p_x;
  assign unit.add_ZD = p_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      k_reg          <= '0;
      idx            <= '0;
      p_x            <= '0;
      p_z            <= '0;
      r0_x           <= '0;
      r0_z           <= '0;
      r1_x           <= '0;
      r1_z           <= '0;
      dbl_cx         <= '0;
      dbl_cz         <= '0;
      add_cx         <= '0;
      add_cz         <= '0;
      bit_cur        <= 1'b0;
      dbl_done       <= 1'b0;
      add_done       <= 1'b0;
      zero_flag      <= 1'b0;
      busy           <= 1'b0;
      ready          <= 1'b0;
      err_zero       <= 1'b0;
      X_out          <= '0;
      Z_out          <= '0;
      unit.dbl_start <= 1'b0;
      unit.dbl_X     <= '0;
      unit.dbl_Z     <= '0;
      unit.add_start <= 1'b0;
      unit.add_X0    <= '0;
      unit.add_Z0    <= '0;
      unit.add_X1    <= '0;
      unit.add_Z1    <= '0;
      unit.cfg_A24   <= '0;
      unit.cfg_N     <= '0;
      unit.cfg_n     <= '0;
    end else begin
      ready          <= 1'b0;
      err_zero       <= 1'b0;
      unit.dbl_start <= 1'b0;
      unit.add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_reg        <= k;
            p_x          <= X_P;
            p_z          <= Z_P;
            unit.cfg_A24 <= A24;
            unit.cfg_N   <= N;
            unit.cfg_n   <= n;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (k_reg == '0) begin
            r0_x      <= '0;
            r0_z      <= '0;
            zero_flag <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            r0_x      <= p_x;
            r0_z      <= p_z;
            zero_flag <= 1'b0;
            idx       <= IW'(K_WIDTH - 1);
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (k_reg[idx]) begin
            if (idx == '0) begin
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= INIT;
            end
          end else begin
            idx <= idx - 1'b1;
          end
        end
        INIT: begin
          unit.dbl_X     <= p_x;
          unit.dbl_Z     <= p_z;
          unit.dbl_start <= 1'b1;
          state          <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (unit.dbl_ready) begin
            r1_x  <= unit.dbl_X_r;
            r1_z  <= unit.dbl_Z_r;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bit_cur        <= k_reg[idx];
          unit.add_X0    <= r0_x;
          unit.add_Z0    <= r0_z;
          unit.add_X1    <= r1_x;
          unit.add_Z1    <= r1_z;
          unit.dbl_X     <= k_reg[idx] ? r1_x : r0_x;
          unit.dbl_Z     <= k_reg[idx] ? r1_z : r0_z;
          unit.dbl_start <= 1'b1;
          unit.add_start <= 1'b1;
          state          <= WAIT;
        end
        WAIT: begin
          if (unit.dbl_ready && !dbl_done) begin
            dbl_done <= 1'b1;
            dbl_cx   <= unit.dbl_X_r;
            dbl_cz   <= unit.dbl_Z_r;
          end
          if (unit.add_ready && !add_done) begin
            add_done <= 1'b1;
            add_cx   <= unit.add_X_r;
            add_cz   <= unit.add_Z_r;
          end
          if (step_done) begin
            if (bit_cur) begin
              r0_x <= ares_x;
              r0_z <= ares_z;
              r1_x <= dres_x;
              r1_z <= dres_z;
            end else begin
              r1_x <= ares_x;
              r1_z <= ares_z;
              r0_x <= dres_x;
              r0_z <= dres_z;
            end
            dbl_done <= 1'b0;
            add_done <= 1'b0;
            if (idx == '0) begin
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          ready    <= 1'b1;
          err_zero <= zero_flag;
          X_out    <= r0_x;
          Z_out    <= r0_z;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LADDER_CYCLE_CNT_EN
  // Zeroed as a run enters LOAD, so the count equals the number of busy cycles of that run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mont_ladder_ctrl.sv
// Self-checking bench for mont_ladder_ctrl with stub doubler (operand+1) and adder (X0+X1, Z0+Z1)
// of programmable latency, compared against a software Montgomery ladder on the same stub arithmetic.
module tb_mont_ladder_ctrl;
  localparam int NW = 64;
  localparam int WW = 32;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, ready, err_zero;
  logic [KW-1:0] k = '0;
  logic [NW-1:0] X_P = '0, Z_P = '0, A24 = '0, N = '0;
  logic [WW-1:0] n = '0;
  logic [NW-1:0] X_out, Z_out;
`ifdef LADDER_CYCLE_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  mont_ladder_ctrl_if #(.NUM_WIDTH(NW), .WORD_WIDTH(WW)) uif ();

  mont_ladder_ctrl #(.NUM_WIDTH(NW), .WORD_WIDTH(WW), .K_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .ready(ready), .err_zero(err_zero),
    .k(k), .X_P(X_P), .Z_P(Z_P), .A24(A24), .N(N), .n(n),
    .X_out(X_out), .Z_out(Z_out), .unit(uif)
`ifdef LADDER_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int dlat = 2, alat = 2;
  bit adup = 1'b0;
  int dbl_cnt = 0, add_cnt = 0, proto_err = 0;
  logic [NW-1:0] dbl_ops_x[$];

  logic [NW-1:0] ox, oz, x6, z6, exp_a24;
  logic          ez;
  int            lat, w, rdy_seen;
  bit            got;
  logic [KW-1:0] kr;

  // Doubler stub: result = operand + 1 after dlat cycles; flags restarts and operand changes while pending.
  initial begin : dbl_stub
    int cnt;
    logic [NW-1:0] sx, sz;
    cnt = 0; sx = '0; sz = '0;
    uif.dbl_ready = 1'b0; uif.dbl_X_r = '0; uif.dbl_Z_r = '0;
    forever begin
      @(negedge clk);
      uif.dbl_ready = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt > 0) begin
          if (uif.dbl_X !== sx || uif.dbl_Z !== sz) proto_err++;
          cnt--;
          if (cnt == 0) begin
            uif.dbl_ready = 1'b1; uif.dbl_X_r = sx + 1; uif.dbl_Z_r = sz + 1;
          end
        end
        if (uif.dbl_start) begin
          if (cnt > 0) proto_err++;
          dbl_cnt++;
          dbl_ops_x.push_back(uif.dbl_X);
          sx = uif.dbl_X; sz = uif.dbl_Z; cnt = dlat;
        end
      end
    end
  end

  // Adder stub: result = (X0+X1, Z0+Z1); optional duplicate ready with a garbage result.
  initial begin : add_stub
    int cnt, dupc;
    logic [NW-1:0] s0x, s0z, s1x, s1z;
    cnt = 0; dupc = 0; s0x = '0; s0z = '0; s1x = '0; s1z = '0;
    uif.add_ready = 1'b0; uif.add_X_r = '0; uif.add_Z_r = '0;
    forever begin
      @(negedge clk);
      uif.add_ready = 1'b0;
      if (rst) begin cnt = 0; dupc = 0; end
      else begin
        if (dupc > 0) begin
          dupc = 0; uif.add_ready = 1'b1; uif.add_X_r = '1; uif.add_Z_r = '1;
        end
        if (cnt > 0) begin
          if (uif.add_X0 !== s0x || uif.add_X1 !== s1x || uif.add_Z0 !== s0z ||
              uif.add_Z1 !== s1z || uif.add_XD !== X_P_latched() ) proto_err++;
          cnt--;
          if (cnt == 0) begin
            uif.add_ready = 1'b1; uif.add_X_r = s0x + s1x; uif.add_Z_r = s0z + s1z;
            if (adup) dupc = 1;
          end
        end
        if (uif.add_start) begin
          if (cnt > 0) proto_err++;
          add_cnt++;
          s0x = uif.add_X0; s0z = uif.add_Z0; s1x = uif.add_X1; s1z = uif.add_Z1; cnt = alat;
        end
      end
    end
  end

  logic [NW-1:0] p_latched = '0;
  function automatic logic [NW-1:0] X_P_latched();
    return p_latched;
  endfunction

  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference ladder: R0=P, R1=2P, then per bit b: R(1-b) = R0+R1, R(b) = 2R(b).
  function automatic void ladder_ref(input logic [KW-1:0] kv, input logic [NW-1:0] px, pz,
                                     output logic [NW-1:0] rx, rz, output int nd, na,
                                     output bit rez);
    int m;
    logic [NW-1:0] x0, z0, x1, z1, tx, tz;
    m = -1; nd = 0; na = 0; x1 = '0; z1 = '0;
    for (int j = KW - 1; j >= 0; j--) if (kv[j] && m < 0) m = j;
    rez = (m < 0);
    if (m < 0) begin rx = '0; rz = '0; return; end
    x0 = px; z0 = pz;
    if (m > 0) begin x1 = px + 1; z1 = pz + 1; nd = 1; end
    for (int j = m - 1; j >= 0; j--) begin
      tx = x0 + x1; tz = z0 + z1; na++; nd++;
      if (kv[j]) begin x0 = tx; z0 = tz; x1 = x1 + 1; z1 = z1 + 1; end
      else       begin x1 = tx; z1 = tz; x0 = x0 + 1; z0 = z0 + 1; end
    end
    rx = x0; rz = z0;
  endfunction

  task automatic launch(input logic [KW-1:0] kv, input logic [NW-1:0] px, pz,
                        input int dl, al, input bit dup);
    dlat = dl; alat = al; adup = dup;
    dbl_cnt = 0; add_cnt = 0; proto_err = 0; dbl_ops_x.delete();
    k = kv; X_P = px; Z_P = pz; p_latched = px;
    A24 = {$urandom, $urandom}; N = {$urandom, $urandom}; n = $urandom;
    exp_a24 = A24;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    got = 1'b0; lat = 0; ox = 'x; oz = 'x; ez = 1'bx;
    while (!got && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if (ready) begin got = 1'b1; ox = X_out; oz = Z_out; ez = err_zero; end
    end
  endtask

  task automatic verify_run(input string tag, input logic [KW-1:0] kv, input logic [NW-1:0] px, pz);
    logic [NW-1:0] rx, rz;
    int nd, na;
    bit rez;
    ladder_ref(kv, px, pz, rx, rz, nd, na, rez);
    chk({tag, " done"}, NW'(got), NW'(1));
    chk({tag, " X_out"}, ox, rx);
    chk({tag, " Z_out"}, oz, rz);
    chk({tag, " err_zero"}, NW'(ez), NW'(rez));
    chk({tag, " dbl_starts"}, NW'(dbl_cnt), NW'(nd));
    chk({tag, " add_starts"}, NW'(add_cnt), NW'(na));
    chk({tag, " protocol"}, NW'(proto_err), NW'(0));
    @(posedge clk); #1;
    chk({tag, " ready_pulse"}, NW'(ready), NW'(0));
    chk({tag, " err_pulse"}, NW'(err_zero), NW'(0));
    chk({tag, " busy_after"}, NW'(busy), NW'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", NW'(busy), NW'(0));
    chk("reset ready", NW'(ready), NW'(0));
    chk("reset err_zero", NW'(err_zero), NW'(0));
    chk("reset X_out", X_out, '0);
    chk("reset dbl_start", NW'(uif.dbl_start), NW'(0));
    chk("reset cfg_N", uif.cfg_N, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    launch(16'd5, 64'h10, 64'h20, 3, 2, 1'b0);
    chk("k5 busy", NW'(busy), NW'(1));
    wait_done(3000);
    chk("k5 step2 dbl operand", (dbl_ops_x.size() > 2) ? dbl_ops_x[2] : 'x, 64'h21);
    chk("k5 cfg_A24", uif.cfg_A24, exp_a24);
    verify_run("k5", 16'd5, 64'h10, 64'h20);

    launch(16'd0, 64'h55, 64'h66, 2, 2, 1'b0);
    wait_done(3000);
    chk("k0 latency", NW'(lat), NW'(2));
    verify_run("k0", 16'd0, 64'h55, 64'h66);

    launch(16'd1, 64'h1234, 64'h5678, 2, 2, 1'b0);
    wait_done(3000);
    chk("k1 latency", NW'(lat), NW'(KW + 2));
    verify_run("k1", 16'd1, 64'h1234, 64'h5678);

    launch(16'd6, 64'hABC, 64'hDEF, 30, 10, 1'b0);
    wait_done(3000);
    x6 = ox; z6 = oz;
    verify_run("k6 add10 dbl30", 16'd6, 64'hABC, 64'hDEF);
    launch(16'd6, 64'hABC, 64'hDEF, 10, 30, 1'b0);
    wait_done(3000);
    chk("k6 swap same X", ox, x6);
    chk("k6 swap same Z", oz, z6);
    verify_run("k6 add30 dbl10", 16'd6, 64'hABC, 64'hDEF);
    launch(16'd6, 64'hABC, 64'hDEF, 7, 7, 1'b0);
    wait_done(3000);
    verify_run("k6 equal", 16'd6, 64'hABC, 64'hDEF);

    launch(16'hB5, 64'h31, 64'h47, 8, 2, 1'b1);
    wait_done(3000);
    verify_run("dup add ready", 16'hB5, 64'h31, 64'h47);

    launch(16'h00FF, 64'h777, 64'h999, 3, 4, 1'b0);
    w = 0;
    while (add_cnt < 2 && w < 500) begin @(posedge clk); #1; w++; end
    chk("rst reached second wait", NW'(add_cnt >= 2), NW'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst busy", NW'(busy), NW'(0));
    chk("rst ready", NW'(ready), NW'(0));
    chk("rst X_out", X_out, '0);
    chk("rst Z_out", Z_out, '0);
    chk("rst dbl_X", uif.dbl_X, '0);
    chk("rst cfg_A24", uif.cfg_A24, '0);
    rst = 1'b0;
    rdy_seen = 0;
    repeat (20) begin @(posedge clk); #1; if (ready) rdy_seen++; end
    chk("rst no ready", NW'(rdy_seen), NW'(0));
    launch(16'd2, 64'h40, 64'h50, 2, 3, 1'b0);
    wait_done(3000);
    verify_run("after rst k2", 16'd2, 64'h40, 64'h50);

    launch(16'h002D, 64'h91, 64'h92, 3, 3, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    k = 16'h0013; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3000);
    verify_run("start while busy", 16'h002D, 64'h91, 64'h92);

    for (int r = 0; r < 8; r++) begin
      kr = KW'($urandom);
      launch(kr, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(1, 5), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
      wait_done(3000);
      verify_run($sformatf("random %0d k=%0h", r, kr), kr, p_latched, Z_P);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mont_ladder_ctrl.md
Name: mont_ladder_ctrl

Overview:
- Sequences one external x-only point doubler and one external differential point adder through a Montgomery ladder.
- Computes [k]P in projective (X:Z) form for ECM stage 1.
- Owns the ladder registers R0/R1, the scalar shift register and the two units' start/ready handshakes.
- Forwards curve/modulus configuration to both units.

Parameters:
- NUM_WIDTH, 256, width of coordinates, A24 and N.
- WORD_WIDTH, 32, width of Montgomery constant n.
- K_WIDTH, 64, scalar width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin scalar multiplication; sampled only in IDLE
- busy  out  1  high from LOAD through WAIT
- ready  out  1  one-cycle pulse, result valid
- err_zero  out  1  one-cycle pulse with ready when k==0
- k  in  K_WIDTH  scalar
- X_P, Z_P  in  NUM_WIDTH  base point (Montgomery domain)
- A24, N  in  NUM_WIDTH  curve constant and modulus
- n  in  WORD_WIDTH  -N^-1 mod 2^WORD_WIDTH
- X_out, Z_out  out  NUM_WIDTH  result R0
- cfg_A24, cfg_N  out  NUM_WIDTH  registered copies to both units
- cfg_n  out  WORD_WIDTH  registered copy to both units
- dbl_start  out  1  one-cycle start pulse to doubler
- dbl_X, dbl_Z  out  NUM_WIDTH  doubler operand
- dbl_ready  in  1  doubler done pulse
- dbl_X_r, dbl_Z_r  in  NUM_WIDTH  doubler result, valid at dbl_ready
- add_start  out  1  one-cycle start pulse to adder
- add_X0, add_Z0, add_X1, add_Z1  out  NUM_WIDTH  adder operands R0, R1
- add_XD, add_ZD  out  NUM_WIDTH  difference point, always the latched P
- add_ready  in  1  adder done pulse
- add_X_r, add_Z_r  in  NUM_WIDTH  adder result, valid at add_ready

Behaviour:
- Reset: rst synchronous, active-high.
  - All outputs and internal registers are 0; state is IDLE.
  - Reset mid-operation aborts immediately, with no ready pulse.
  - Both units share rst.
- IDLE:
  - start=1: latch k, X_P, Z_P, A24, N, n; go to LOAD.
  - start while busy is ignored.
- LOAD:
  - k==0: go to DONE with err_zero=1; X_out=Z_out=0.
  - Otherwise: R0<=P; bit counter i<=K_WIDTH-1; go to SCAN.
- SCAN: one bit per cycle while k[i]==0, i decrements. On k[i]==1:
  - i==0 (k==1): go to DONE with R0=P; no unit is started.
  - Otherwise: i<=i-1; go to INIT.
- INIT: pulse dbl_start with dbl operand=P; go to INIT_WAIT.
- INIT_WAIT: on dbl_ready, R1<=dbl result; go to ISSUE.
- ISSUE, with b=k[i]:
  - Pulse dbl_start and add_start in the same cycle.
  - add operands are R0, R1; difference is P.
  - dbl operand is R1 if b else R0.
  - Go to WAIT.
- WAIT:
  - Each unit's ready sets a sticky done flag and captures its result.
  - Ready pulses may arrive in any order, or in the same cycle.
  - When both flags are set:
    - b=1: R0<=add result, R1<=dbl result.
    - b=0: R1<=add result, R0<=dbl result.
    - Clear the flags.
    - i==0: go to DONE. Otherwise i<=i-1 and go to ISSUE.
  - A second ready from the same unit within one step is ignored.
- DONE: ready=1 for one cycle; X_out/Z_out<=R0; return to IDLE.
  - X_out/Z_out hold until the next LOAD.
- Register stability:
  - dbl_X/dbl_Z, add_* operands and cfg_* are registered.
  - They are stable from the start pulse until the corresponding ready.
- Latency: for MSB position m, latency is 3 + (K_WIDTH-1-m) + (m+1)·(unit step) cycles, plus handshake overhead.
  - Unit count: m+1 doublings, m additions.

Optional Feature:
- Macro: LADDER_CYCLE_CNT_EN.
- Defined: adds output port cycle_cnt, 32 bits.
  - Cleared in LOAD; increments every busy cycle; saturates at 0xFFFFFFFF.
  - Holds its value after ready until the next LOAD.
- Undefined: port absent; no counter logic.

Test Plan:
- Bench setup: stub units with programmable latency and tagged results (dbl returns operand+1, add returns X0+X1).
- k=0, start -> ready and err_zero high in the same single cycle, X_out=Z_out=0, zero dbl_start/add_start pulses.
- k=1, X_P=0x1234 -> ready, X_out=0x1234, Z_out=Z_P, no unit starts; latency K_WIDTH+2 cycles.
- k=5 (binary 101) -> exactly 3 dbl_start and 2 add_start pulses; step-2 dbl operand is R1; final R0 matches the software ladder model on stub arithmetic.
- k=6, adder latency 10 and doubler latency 30, then swapped, then equal -> identical results in all three runs; no ISSUE before both ready pulses.
- rst asserted during the second WAIT of k=0xFF -> next cycle busy=0, ready=0, outputs 0; a following k=2 run completes correctly.
- start pulsed while busy with different k -> ignored; result matches the original k.
